// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1/2 stop.
// Ports: clk, reset, prediv/parity_en/parity_odd/stop2/data/valid in; ready, txd, busy out.
module uart_tx #(
  parameter int DIV_WIDTH = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] prediv,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 par_en_q, par_en_d;
  logic                 par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic                 txd_q, txd_d;
  logic                 bit_end;

  assign ready   = (state_q == S_IDLE) && !reset;
  assign busy    = (state_q != S_IDLE);
  assign txd     = txd_q;
  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid && ready) begin
          state_d  = S_START;
          shift_d  = data;
          div_d    = prediv;
          cnt_d    = prediv;
          idx_d    = '0;
          par_en_d = parity_en;
          par_d    = (^data) ^ parity_odd;
          stop2_d  = stop2;
        end
      end
      default: begin
        if (!bit_end) begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end else begin
          // every bit reloads from the latched divider
          cnt_d = div_q;
          unique case (state_q)
            S_START: state_d = S_DATA;
            S_DATA: begin
              shift_d = shift_q >> 1;
              idx_d   = idx_q + IW'(1);
              if (idx_q == IW'(DATA_BITS - 1)) begin
                state_d = par_en_q ? S_PARITY : S_STOP1;
              end
            end
            S_PARITY: state_d = S_STOP1;
            S_STOP1:  state_d = stop2_q ? S_STOP2 : S_IDLE;
            default:  state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // txd is registered from the next state so it lines up with state_q
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued with their config,
// a negedge monitor decodes txd against the expected frame bit list.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] prediv;
  logic       parity_en, parity_odd, stop2;
  logic [7:0] data;
  logic       valid;
  logic       ready, txd, busy;

  uart_tx #(.DIV_WIDTH(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .prediv(prediv),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .data(data), .valid(valid), .ready(ready), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         pd;
    bit         pe, po, s2;
    int         acc;
  } frm_t;

  frm_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   done_frames = 0;
  int   last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // acceptance tracker: pushes the config seen on a handshake edge
  always @(posedge clk) begin
    frm_t f;
    if (valid && ready && !reset) begin
      f.d = data; f.pd = int'(prediv);
      f.pe = parity_en; f.po = parity_odd; f.s2 = stop2;
      f.acc = cyc;
      q.push_back(f);
      pushed++;
      last_acc = cyc;
    end
    cyc++;
  end

  // monitor
  bit   in_frame = 0, post = 0, stray = 0;
  frm_t cur;
  bit   ex[12];
  int   nb, per, pos;
  logic s_txd, s_busy;

  always @(negedge clk) begin
    int b;
    if (reset) begin
      in_frame = 0; post = 0; stray = 0;
      q.delete();
    end else begin
      if (post) begin
        post = 0;
        chk("idle_gap {txd,ready,busy}", {29'd0, txd, ready, busy}, 32'd6);
      end
      if (stray && txd === 1'b1) stray = 0;
      if (!in_frame && !stray && txd === 1'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
          stray = 1;
        end else begin
          cur = q.pop_front();
          chk("start_latency", cyc - cur.acc, 32'd1);
          ex[0] = 1'b0;
          for (int i = 0; i < 8; i++) ex[1+i] = cur.d[i];
          nb = 9;
          if (cur.pe) begin ex[nb] = (^cur.d) ^ cur.po; nb++; end
          ex[nb] = 1'b1; nb++;
          if (cur.s2) begin ex[nb] = 1'b1; nb++; end
          per = cur.pd + 1;
          pos = 0;
          in_frame = 1;
        end
      end
      if (in_frame) begin
        b = pos / per;
        if (pos % per == 0) begin s_txd = ex[b]; s_busy = 1'b1; end
        if ((txd !== ex[b] || busy !== 1'b1) && s_txd === ex[b] && s_busy === 1'b1) begin
          s_txd = txd; s_busy = busy;
        end
        pos++;
        if (pos % per == 0)
          chk($sformatf("frame%0d_bit%0d {busy,txd}", done_frames, b),
              {30'd0, s_busy, s_txd}, {30'd0, 1'b1, ex[b]});
        if (pos == nb * per) begin
          in_frame = 0; post = 1; done_frames++;
        end
      end
    end
  end

  task automatic accept_wait(input bit hold);
    int n = 0;
    do begin @(posedge clk); n++; end while (!ready && n < 6000);
    if (!ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end
    #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int pd, input bit pe,
                      input bit po, input bit s2, input bit hold);
    data = d; prediv = pd[7:0];
    parity_en = pe; parity_odd = po; stop2 = s2;
    valid = 1'b1;
    accept_wait(hold);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((in_frame || q.size() != 0 || busy) && n < budget);
    if (n >= budget) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int a1;
    reset = 1'b1; valid = 1'b0; data = '0; prediv = '0;
    parity_en = 0; parity_odd = 0; stop2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset {txd,busy,ready}", {29'd0, txd, busy, ready}, 32'd4);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;

    // 1: plain 8N1 with 4-cycle bits
    send(8'h55, 3, 0, 0, 0, 0);
    wait_idle(200);

    // 2: even then odd parity, 1-cycle bits
    send(8'h07, 0, 1, 0, 0, 0);
    wait_idle(100);
    send(8'h07, 0, 1, 1, 0, 0);
    wait_idle(100);

    // 3: valid held across two 2-stop frames
    send(8'hA3, 1, 0, 0, 1, 1);
    a1 = last_acc;
    data = 8'h3C;
    accept_wait(0);
    chk("b2b_gap", last_acc - a1, 32'd23);
    wait_idle(200);

    // 4: config changes mid-frame ignored
    send(8'h55, 3, 0, 0, 0, 1);
    a1 = last_acc;
    repeat (10) @(posedge clk);
    #1 data = 8'hFF; prediv = 8'd7;
    accept_wait(0);
    chk("midframe_gap", last_acc - a1, 32'd41);
    wait_idle(400);

    // 5: reset during data bit 3
    send(8'h55, 3, 0, 0, 0, 0);
    repeat (16) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort {txd,busy,ready}", {29'd0, txd, busy, ready}, 32'd4);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    send(8'h81, 3, 0, 0, 0, 0);
    wait_idle(200);

    // random frames
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      send(8'($urandom), $urandom_range(0, 4), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      if (valid) begin
        data = 8'($urandom);
        accept_wait(0);
      end
    end
    wait_idle(3000);

    // 6: maximum divider
    send(8'h00, 255, 0, 0, 0, 0);
    wait_idle(4000);

    chk("queue_empty", q.size(), 32'd0);
    chk("frames_done", done_frames, pushed - 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
